// File: rtl/ysyx_23060208_axi_arbiter_pkg.sv
// rtl/ysyx_23060208_axi_arbiter_pkg.sv - shared encodings for the IFU/EXU AXI arbiter
// Purpose: FSM state encodings, read-path owner encodings, AXI field widths and resp codes.
// Ports: none (package).
package ysyx_23060208_axi_arbiter_pkg;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;

    typedef enum logic [2:0] {
        AXI_ARB_IDLE   = 3'd0,
        AXI_ARB_R_ADDR = 3'd1,
        AXI_ARB_R_DATA = 3'd2,
        AXI_ARB_W_ADDR = 3'd3,
        AXI_ARB_W_DATA = 3'd4,
        AXI_ARB_W_RESP = 3'd5
    } arb_state_t;

    typedef enum logic {
        ARB_OWN_IFU = 1'b0,
        ARB_OWN_EXU = 1'b1
    } arb_owner_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_23060208_axi_ar_reg.sv
// rtl/ysyx_23060208_axi_ar_reg.sv - latched address-channel holding register
// Purpose: captures an accepted AR/AW beat and presents it to the slave until the
//          slave handshakes, so a master that pulses valid for one cycle is still served.
// Ports:
//   clock, reset        clock, asynchronous active-low reset
//   load                capture next_* and raise valid
//   next_addr..burst    payload to capture
//   valid / ready       slave-side handshake
//   addr..burst         held payload (stable while valid && !ready)
module ysyx_23060208_axi_ar_reg
    import ysyx_23060208_axi_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic [ADDR_WIDTH-1:0]  next_addr,
    input  logic [ID_WIDTH-1:0]    next_id,
    input  logic [AXI_LEN_W-1:0]   next_len,
    input  logic [AXI_SIZE_W-1:0]  next_size,
    input  logic [AXI_BURST_W-1:0] next_burst,
    output logic                   valid,
    input  logic                   ready,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic [ID_WIDTH-1:0]    id,
    output logic [AXI_LEN_W-1:0]   len,
    output logic [AXI_SIZE_W-1:0]  size,
    output logic [AXI_BURST_W-1:0] burst
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            addr  <= '0;
            id    <= '0;
            len   <= '0;
            size  <= '0;
            burst <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= next_addr;
            id    <= next_id;
            len   <= next_len;
            size  <= next_size;
            burst <= next_burst;
        end else if (valid && ready) begin
            // Payload is left as-is after the handshake; only valid drops.
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_23060208_axi_arbiter.sv
// rtl/ysyx_23060208_axi_arbiter.sv - 2:1 AXI4 arbiter, IFU (read) and EXU (read+write)
// Purpose: shares one AXI slave port between IFU and EXU, one whole transaction at a
//          time, round-robin between masters, EXU write ahead of EXU read.
// Ports:
//   clock, reset              clock, asynchronous active-low reset
//   ifu_ar*/ifu_r*            IFU read address / read data channels
//   exu_ar*/exu_r*            EXU read address / read data channels
//   exu_aw*/exu_w*/exu_b*     EXU write address / data / response channels
//   s_ar*,s_r*,s_aw*,s_w*,s_b* slave-side mirror of the above
module ysyx_23060208_axi_arbiter
    import ysyx_23060208_axi_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                      clock,
    input  logic                      reset,

    input  logic                      ifu_arvalid,
    output logic                      ifu_arready,
    input  logic [DATA_WIDTH-1:0]     ifu_araddr,
    input  logic [ID_WIDTH-1:0]       ifu_arid,
    input  logic [AXI_LEN_W-1:0]      ifu_arlen,
    input  logic [AXI_SIZE_W-1:0]     ifu_arsize,
    input  logic [AXI_BURST_W-1:0]    ifu_arburst,
    output logic                      ifu_rvalid,
    input  logic                      ifu_rready,
    output logic [2*DATA_WIDTH-1:0]   ifu_rdata,
    output logic [1:0]                ifu_rresp,
    output logic                      ifu_rlast,
    output logic [ID_WIDTH-1:0]       ifu_rid,

    input  logic                      exu_arvalid,
    output logic                      exu_arready,
    input  logic [DATA_WIDTH-1:0]     exu_araddr,
    input  logic [ID_WIDTH-1:0]       exu_arid,
    input  logic [AXI_LEN_W-1:0]      exu_arlen,
    input  logic [AXI_SIZE_W-1:0]     exu_arsize,
    input  logic [AXI_BURST_W-1:0]    exu_arburst,
    output logic                      exu_rvalid,
    input  logic                      exu_rready,
    output logic [2*DATA_WIDTH-1:0]   exu_rdata,
    output logic [1:0]                exu_rresp,
    output logic                      exu_rlast,
    output logic [ID_WIDTH-1:0]       exu_rid,

    input  logic                      exu_awvalid,
    output logic                      exu_awready,
    input  logic [DATA_WIDTH-1:0]     exu_awaddr,
    input  logic [ID_WIDTH-1:0]       exu_awid,
    input  logic [AXI_LEN_W-1:0]      exu_awlen,
    input  logic [AXI_SIZE_W-1:0]     exu_awsize,
    input  logic [AXI_BURST_W-1:0]    exu_awburst,
    input  logic                      exu_wvalid,
    output logic                      exu_wready,
    input  logic [2*DATA_WIDTH-1:0]   exu_wdata,
    input  logic [DATA_WIDTH/4-1:0]   exu_wstrb,
    input  logic                      exu_wlast,
    output logic                      exu_bvalid,
    input  logic                      exu_bready,
    output logic [1:0]                exu_bresp,
    output logic [ID_WIDTH-1:0]       exu_bid,

    output logic                      s_arvalid,
    input  logic                      s_arready,
    output logic [DATA_WIDTH-1:0]     s_araddr,
    output logic [ID_WIDTH-1:0]       s_arid,
    output logic [AXI_LEN_W-1:0]      s_arlen,
    output logic [AXI_SIZE_W-1:0]     s_arsize,
    output logic [AXI_BURST_W-1:0]    s_arburst,
    input  logic                      s_rvalid,
    output logic                      s_rready,
    input  logic [2*DATA_WIDTH-1:0]   s_rdata,
    input  logic [1:0]                s_rresp,
    input  logic                      s_rlast,
    input  logic [ID_WIDTH-1:0]       s_rid,

    output logic                      s_awvalid,
    input  logic                      s_awready,
    output logic [DATA_WIDTH-1:0]     s_awaddr,
    output logic [ID_WIDTH-1:0]       s_awid,
    output logic [AXI_LEN_W-1:0]      s_awlen,
    output logic [AXI_SIZE_W-1:0]     s_awsize,
    output logic [AXI_BURST_W-1:0]    s_awburst,
    output logic                      s_wvalid,
    input  logic                      s_wready,
    output logic [2*DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/4-1:0]   s_wstrb,
    output logic                      s_wlast,
    input  logic                      s_bvalid,
    output logic                      s_bready,
    input  logic [1:0]                s_bresp,
    input  logic [ID_WIDTH-1:0]       s_bid
);

    arb_state_t state;
    arb_owner_t owner;
    arb_owner_t last_gnt;

    logic idle;
    logic exu_req;
    logic pick_ifu;
    logic pick_exu_w;
    logic pick_exu_r;
    logic r_data_ifu;
    logic r_data_exu;

    // Gating with reset keeps every ready low while reset is held, even with
    // a master already presenting a request.
    assign idle    = (state == AXI_ARB_IDLE) && reset;
    assign exu_req = exu_awvalid || exu_arvalid;

    // Round-robin: on a tie the master that did not win last time goes first.
    assign pick_ifu   = idle && ifu_arvalid && (!exu_req || last_gnt == ARB_OWN_EXU);
    assign pick_exu_w = idle && exu_awvalid && !pick_ifu;
    assign pick_exu_r = idle && exu_arvalid && !exu_awvalid && !pick_ifu;

    assign ifu_arready = pick_ifu;
    assign exu_arready = pick_exu_r;
    assign exu_awready = pick_exu_w;

    ysyx_23060208_axi_ar_reg #(
        .ADDR_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_ar_reg (
        .clock      (clock),
        .reset      (reset),
        .load       (pick_ifu || pick_exu_r),
        .next_addr  (pick_ifu ? ifu_araddr  : exu_araddr),
        .next_id    (pick_ifu ? ifu_arid    : exu_arid),
        .next_len   (pick_ifu ? ifu_arlen   : exu_arlen),
        .next_size  (pick_ifu ? ifu_arsize  : exu_arsize),
        .next_burst (pick_ifu ? ifu_arburst : exu_arburst),
        .valid      (s_arvalid),
        .ready      (s_arready),
        .addr       (s_araddr),
        .id         (s_arid),
        .len        (s_arlen),
        .size       (s_arsize),
        .burst      (s_arburst)
    );

    ysyx_23060208_axi_ar_reg #(
        .ADDR_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_aw_reg (
        .clock      (clock),
        .reset      (reset),
        .load       (pick_exu_w),
        .next_addr  (exu_awaddr),
        .next_id    (exu_awid),
        .next_len   (exu_awlen),
        .next_size  (exu_awsize),
        .next_burst (exu_awburst),
        .valid      (s_awvalid),
        .ready      (s_awready),
        .addr       (s_awaddr),
        .id         (s_awid),
        .len        (s_awlen),
        .size       (s_awsize),
        .burst      (s_awburst)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= AXI_ARB_IDLE;
            owner    <= ARB_OWN_IFU;
            last_gnt <= ARB_OWN_EXU;
        end else begin
            case (state)
                AXI_ARB_IDLE: begin
                    if (pick_ifu) begin
                        state    <= AXI_ARB_R_ADDR;
                        owner    <= ARB_OWN_IFU;
                        last_gnt <= ARB_OWN_IFU;
                    end else if (pick_exu_w) begin
                        state    <= AXI_ARB_W_ADDR;
                        last_gnt <= ARB_OWN_EXU;
                    end else if (pick_exu_r) begin
                        state    <= AXI_ARB_R_ADDR;
                        owner    <= ARB_OWN_EXU;
                        last_gnt <= ARB_OWN_EXU;
                    end
                end
                AXI_ARB_R_ADDR: begin
                    if (s_arvalid && s_arready) state <= AXI_ARB_R_DATA;
                end
                AXI_ARB_R_DATA: begin
                    if (s_rvalid && s_rready && s_rlast) state <= AXI_ARB_IDLE;
                end
                AXI_ARB_W_ADDR: begin
                    if (s_awvalid && s_awready) state <= AXI_ARB_W_DATA;
                end
                AXI_ARB_W_DATA: begin
                    if (s_wvalid && s_wready && s_wlast) state <= AXI_ARB_W_RESP;
                end
                AXI_ARB_W_RESP: begin
                    if (s_bvalid && s_bready) state <= AXI_ARB_IDLE;
                end
                default: state <= AXI_ARB_IDLE;
            endcase
        end
    end

    // Read data path: only the owner sees valid; payload is a straight wire.
    assign r_data_ifu = (state == AXI_ARB_R_DATA) && (owner == ARB_OWN_IFU);
    assign r_data_exu = (state == AXI_ARB_R_DATA) && (owner == ARB_OWN_EXU);

    assign ifu_rvalid = r_data_ifu && s_rvalid;
    assign ifu_rdata  = s_rdata;
    assign ifu_rresp  = ifu_rvalid ? s_rresp : AXI_RESP_OKAY;
    assign ifu_rlast  = s_rlast;
    assign ifu_rid    = s_rid;

    assign exu_rvalid = r_data_exu && s_rvalid;
    assign exu_rdata  = s_rdata;
    assign exu_rresp  = exu_rvalid ? s_rresp : AXI_RESP_OKAY;
    assign exu_rlast  = s_rlast;
    assign exu_rid    = s_rid;

    assign s_rready = (r_data_ifu && ifu_rready) || (r_data_exu && exu_rready);

    // Write data and response paths belong to the EXU alone.
    assign s_wvalid   = (state == AXI_ARB_W_DATA) && exu_wvalid;
    assign s_wdata    = exu_wdata;
    assign s_wstrb    = exu_wstrb;
    assign s_wlast    = exu_wlast;
    assign exu_wready = (state == AXI_ARB_W_DATA) && s_wready;

    assign exu_bvalid = (state == AXI_ARB_W_RESP) && s_bvalid;
    assign exu_bresp  = exu_bvalid ? s_bresp : AXI_RESP_OKAY;
    assign exu_bid    = s_bid;
    assign s_bready   = (state == AXI_ARB_W_RESP) && exu_bready;

endmodule

// File: tb/tb_ysyx_23060208_axi_arbiter.sv
// tb/tb_ysyx_23060208_axi_arbiter.sv - self-checking bench for the IFU/EXU AXI arbiter
module tb_ysyx_23060208_axi_arbiter;
    import ysyx_23060208_axi_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
    logic [31:0] ifu_araddr;
    logic [3:0]  ifu_arid, ifu_rid;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_arburst, ifu_rresp;
    logic [63:0] ifu_rdata;

    logic        exu_arvalid, exu_arready, exu_rvalid, exu_rready, exu_rlast;
    logic [31:0] exu_araddr;
    logic [3:0]  exu_arid, exu_rid;
    logic [7:0]  exu_arlen;
    logic [2:0]  exu_arsize;
    logic [1:0]  exu_arburst, exu_rresp;
    logic [63:0] exu_rdata;

    logic        exu_awvalid, exu_awready, exu_wvalid, exu_wready, exu_wlast;
    logic        exu_bvalid, exu_bready;
    logic [31:0] exu_awaddr;
    logic [3:0]  exu_awid, exu_bid;
    logic [7:0]  exu_awlen, exu_wstrb;
    logic [2:0]  exu_awsize;
    logic [1:0]  exu_awburst, exu_bresp;
    logic [63:0] exu_wdata;

    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [31:0] s_araddr;
    logic [3:0]  s_arid, s_rid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst, s_rresp;
    logic [63:0] s_rdata;

    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic [31:0] s_awaddr;
    logic [3:0]  s_awid, s_bid;
    logic [7:0]  s_awlen, s_wstrb;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst, s_bresp;
    logic [63:0] s_wdata;

    ysyx_23060208_axi_arbiter #(.DATA_WIDTH(32), .ID_WIDTH(4)) dut (
        .clock(clock), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_arid(ifu_arid), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid),
        .exu_arvalid(exu_arvalid), .exu_arready(exu_arready), .exu_araddr(exu_araddr),
        .exu_arid(exu_arid), .exu_arlen(exu_arlen), .exu_arsize(exu_arsize), .exu_arburst(exu_arburst),
        .exu_rvalid(exu_rvalid), .exu_rready(exu_rready), .exu_rdata(exu_rdata),
        .exu_rresp(exu_rresp), .exu_rlast(exu_rlast), .exu_rid(exu_rid),
        .exu_awvalid(exu_awvalid), .exu_awready(exu_awready), .exu_awaddr(exu_awaddr),
        .exu_awid(exu_awid), .exu_awlen(exu_awlen), .exu_awsize(exu_awsize), .exu_awburst(exu_awburst),
        .exu_wvalid(exu_wvalid), .exu_wready(exu_wready), .exu_wdata(exu_wdata),
        .exu_wstrb(exu_wstrb), .exu_wlast(exu_wlast),
        .exu_bvalid(exu_bvalid), .exu_bready(exu_bready), .exu_bresp(exu_bresp), .exu_bid(exu_bid),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rid(s_rid),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboards: expected slave-side address beats and expected read data.
    logic [43:0] ar_q[$];
    logic [43:0] aw_q[$];
    logic [63:0] rd_q[$];

    typedef struct {
        bit ifu;
        bit exu_ar;
        bit exu_aw;
        int win;     // 0 none, 1 IFU AR, 2 EXU AR, 3 EXU AW
    } arb_vec_t;

    arb_vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_no_grant(input string name);
        check(name, {ifu_arready, exu_arready, exu_awready}, 3'b000);
    endtask

    // Present requests at a negedge, check the combinational grant, queue the
    // expected slave address beat, and advance to the next negedge.
    task automatic arb(input bit i, input bit er, input bit ew, input int win, input int idx);
        ifu_arvalid = i;
        exu_arvalid = er;
        exu_awvalid = ew;
        ifu_araddr  = 32'h8000_0000 + 32'(idx * 8);
        exu_araddr  = 32'h9000_0000 + 32'(idx * 8);
        exu_awaddr  = 32'ha000_0000 + 32'(idx * 8);
        #1;
        check("grant", {ifu_arready, exu_arready, exu_awready},
              {win == 1, win == 2, win == 3});
        check("no_s_valid_at_grant", {s_arvalid, s_awvalid}, 2'b00);
        if (win == 1) ar_q.push_back({ifu_arid, ifu_arlen, ifu_araddr});
        if (win == 2) ar_q.push_back({exu_arid, exu_arlen, exu_araddr});
        if (win == 3) aw_q.push_back({exu_awid, exu_awlen, exu_awaddr});
        @(negedge clock);
    endtask

    task automatic read_txn(input bit is_ifu, input int len, input int ar_delay, input logic [63:0] base);
        logic [43:0] exp_ar;
        logic own_v, own_l, oth_v;
        logic [63:0] own_d;
        logic [3:0] own_id;
        exp_ar = ar_q.pop_front();
        for (int d = 0; d <= ar_delay; d++) begin
            s_arready = (d == ar_delay);
            #1;
            check("s_arvalid", s_arvalid, 1'b1);
            check("s_ar_payload", {s_arid, s_arlen, s_araddr}, exp_ar);
            check("r_addr_no_grant", {ifu_arready, exu_arready, exu_awready}, 3'b000);
            @(negedge clock);
        end
        s_arready = 1'b0;
        for (int b = 0; b <= len; b++) begin
            s_rvalid = 1'b1;
            s_rdata  = base + 64'(b);
            s_rlast  = (b == len);
            s_rid    = 4'hf;
            s_rresp  = AXI_RESP_OKAY;
            rd_q.push_back(base + 64'(b));
            #1;
            own_v  = is_ifu ? ifu_rvalid : exu_rvalid;
            own_d  = is_ifu ? ifu_rdata  : exu_rdata;
            own_l  = is_ifu ? ifu_rlast  : exu_rlast;
            own_id = is_ifu ? ifu_rid    : exu_rid;
            oth_v  = is_ifu ? exu_rvalid : ifu_rvalid;
            check("owner_rvalid", own_v, 1'b1);
            check("owner_rdata", own_d, rd_q.pop_front());
            check("owner_rlast", own_l, b == len);
            check("owner_rid", own_id, 4'hf);
            check("other_rvalid", oth_v, 1'b0);
            check("s_rready", s_rready, 1'b1);
            check("r_data_s_arvalid", s_arvalid, 1'b0);
            check_no_grant("r_data_no_grant");
            @(negedge clock);
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
    endtask

    task automatic write_txn(input int aw_delay, input int b_delay, input logic [7:0] strb, input logic [63:0] data);
        logic [43:0] exp_aw;
        exp_aw = aw_q.pop_front();
        for (int d = 0; d <= aw_delay; d++) begin
            s_awready = (d == aw_delay);
            #1;
            check("s_awvalid", s_awvalid, 1'b1);
            check("s_aw_payload", {s_awid, s_awlen, s_awaddr}, exp_aw);
            check("w_addr_s_arvalid", s_arvalid, 1'b0);
            check_no_grant("w_addr_no_grant");
            @(negedge clock);
        end
        s_awready  = 1'b0;
        exu_wvalid = 1'b1;
        exu_wdata  = data;
        exu_wstrb  = strb;
        exu_wlast  = 1'b1;
        s_wready   = 1'b1;
        #1;
        check("s_wvalid", s_wvalid, 1'b1);
        check("s_wdata", s_wdata, data);
        check("s_wstrb", s_wstrb, strb);
        check("exu_wready", exu_wready, 1'b1);
        check("w_data_s_awvalid", s_awvalid, 1'b0);
        @(negedge clock);
        exu_wvalid = 1'b0;
        exu_wlast  = 1'b0;
        s_wready   = 1'b0;
        for (int d = 0; d <= b_delay; d++) begin
            s_bvalid = (d == b_delay);
            s_bid    = 4'h3;
            s_bresp  = AXI_RESP_OKAY;
            #1;
            check("exu_bvalid", exu_bvalid, d == b_delay);
            check("s_bready", s_bready, 1'b1);
            check("w_resp_s_valids", {s_arvalid, s_awvalid, s_wvalid}, 3'b000);
            check_no_grant("w_resp_no_grant");
            @(negedge clock);
        end
        s_bvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 2};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 3};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 3};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 2};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 3};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1};

        ifu_arvalid = 0; ifu_araddr = 0; ifu_arid = 4'h1; ifu_arlen = 0; ifu_arsize = 3'd2;
        ifu_arburst = 2'b01; ifu_rready = 1;
        exu_arvalid = 0; exu_araddr = 0; exu_arid = 4'h2; exu_arlen = 0; exu_arsize = 3'd3;
        exu_arburst = 2'b01; exu_rready = 1;
        exu_awvalid = 0; exu_awaddr = 0; exu_awid = 4'h3; exu_awlen = 0; exu_awsize = 3'd3;
        exu_awburst = 2'b01; exu_wvalid = 0; exu_wdata = 0; exu_wstrb = 0; exu_wlast = 0;
        exu_bready = 1;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0; s_rid = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0; s_bid = 0;

        // Reset state, with an IFU request already pending.
        reset = 1'b0;
        ifu_arvalid = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check_no_grant("reset_no_grant");
        check("reset_s_valids", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 5'b0);
        check("reset_s_araddr", s_araddr, 32'h0);
        check("reset_s_awaddr", s_awaddr, 32'h0);
        ifu_arvalid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Single IFU read of 0x8000_0000 returning 0x1234.
        arb(1, 0, 0, 1, 0);
        ifu_arvalid = 0;
        read_txn(1, 0, 0, 64'h1234);

        // Asynchronous reset while the IFU owns R_DATA.
        arb(1, 0, 0, 1, 1);
        ifu_arvalid = 0;
        s_arready = 1'b1;
        @(negedge clock);
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rdata   = 64'hdead;
        #1;
        check("pre_reset_rvalid", ifu_rvalid, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_rvalid", {ifu_rvalid, exu_rvalid}, 2'b00);
        check("async_reset_s_valids", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 5'b0);
        @(negedge clock);
        s_rvalid = 1'b0;
        reset = 1'b1;
        ar_q.delete();
        @(negedge clock);

        // Simultaneous IFU and EXU reads after reset: IFU first, EXU waits.
        arb(1, 1, 0, 1, 2);
        ifu_arvalid = 0;
        read_txn(1, 0, 1, 64'h1000);
        arb(0, 1, 0, 2, 2);
        exu_arvalid = 0;
        read_txn(0, 0, 0, 64'h2000);
        arb(1, 1, 0, 1, 3);
        ifu_arvalid = 0;
        read_txn(1, 0, 0, 64'h3000);
        arb(0, 1, 0, 2, 3);
        exu_arvalid = 0;
        read_txn(0, 0, 0, 64'h4000);

        // EXU write with slow slave; IFU holds a request throughout.
        arb(0, 0, 1, 3, 0);
        exu_awvalid = 0;
        ifu_arvalid = 1;
        write_txn(3, 5, 8'h0f, 64'h1122_3344_5566_7788);
        arb(1, 0, 0, 1, 4);
        ifu_arvalid = 0;
        read_txn(1, 0, 0, 64'h5000);

        // EXU AW and AR together: write finishes before the read address goes out.
        arb(0, 1, 1, 3, 5);
        exu_awvalid = 0;
        write_txn(0, 1, 8'hff, 64'hcafe);
        arb(0, 1, 0, 2, 5);
        exu_arvalid = 0;
        read_txn(0, 0, 0, 64'h6000);

        // IFU burst of four beats.
        ifu_arlen = 8'd3;
        arb(1, 0, 0, 1, 6);
        ifu_arvalid = 0;
        ifu_arlen = 8'd0;
        read_txn(1, 3, 1, 64'h7000);

        // Arbitration table, starting with last grant = IFU.
        for (int k = 0; k < 10; k++) begin
            arb(vecs[k].ifu, vecs[k].exu_ar, vecs[k].exu_aw, vecs[k].win, 10 + k);
            ifu_arvalid = 0;
            exu_arvalid = 0;
            exu_awvalid = 0;
            if (vecs[k].win == 1) read_txn(1, 0, 0, 64'(32'h100 * k));
            if (vecs[k].win == 2) read_txn(0, 0, 0, 64'(32'h100 * k));
            if (vecs[k].win == 3) write_txn(k % 2, 0, 8'hff, 64'(k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
